// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use, branch-in-ID operand, MDU busy and data-memory wait stalls.
// Latency: stall/flush/mdu_start/mdu_done are combinational; mdu_busy and stall_cycles are registered.
// Backpressure: MEM wait freezes F..M and bubbles MEM/WB; other causes hold F/D and bubble ID/EX.
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             use_rsD,
  input  logic             use_rtD,
  input  logic             branchD,
  input  logic             mdu_opD,
  input  logic             hilo_useD,
  input  logic             id_exe_MemRead,
  input  logic             id_exe_RegWrite,
  input  logic [4:0]       id_exe_rd,
  input  logic             exe_mem_MemRead,
  input  logic             exe_mem_RegWrite,
  input  logic [4:0]       exe_mem_rd,
  input  logic             mem_reqM,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [3:0] cnt;

  logic ex_match;
  logic mem_match;
  logic mem_wait;
  logic load_use;
  logic branch_haz;
  logic mdu_haz;
  logic any_stall;

  // Register 0 is hardwired, so a dependency on it is never a hazard.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic urs, input logic urt);
    return (r != 5'd0) && (((r == rs) && urs) || ((r == rt) && urt));
  endfunction

  assign ex_match  = reg_match(id_exe_rd, rsD, rtD, use_rsD, use_rtD);
  assign mem_match = reg_match(exe_mem_rd, rsD, rtD, use_rsD, use_rtD);

  assign mem_wait   = mem_reqM && !dmem_ready;
  assign load_use   = id_exe_MemRead && ex_match;
  assign branch_haz = branchD && ((id_exe_RegWrite && ex_match) ||
                                  (exe_mem_RegWrite && mem_match));

  assign mdu_busy = (state == BUSY);
  assign mdu_done = mdu_busy && (cnt == 4'd0);

  // HI/LO readers are released in the done cycle; a new MDU op still waits for IDLE.
  assign mdu_haz = mdu_busy && (mdu_opD || (hilo_useD && !mdu_done));

  assign any_stall = mem_wait || load_use || branch_haz || mdu_haz;

  assign stallF = any_stall;
  assign stallD = any_stall;
  assign stallE = mem_wait;
  assign stallM = mem_wait;
  assign flushW = mem_wait;
  assign flushE = !mem_wait && (load_use || branch_haz || mdu_haz);

  assign mdu_start = rst_n && (state == IDLE) && mdu_opD &&
                     !mem_wait && !load_use && !branch_haz;

  // The MDU runs free once started, so its countdown ignores pipeline stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start) begin
            state <= BUSY;
            cnt   <= 4'(MDU_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stallF && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
